chunked_seq_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, passing the carry between chunks through a register. Operands enter and results leave through valid/ready handshakes. It is the sequential, width-generic successor to the team's combinational 8-bit ripple-carry adder, for datapaths that trade latency for area.

---
 rtl/chunked_seq_adder_if.sv | 35 +++
 rtl/chunked_seq_adder.sv | 110 +++++++++++
 tb/tb_chunked_seq_adder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/chunked_seq_adder_if.sv
// Operand/result handshake bundle for chunked_seq_adder.
// Port v exists only when CHUNKED_ADDER_OVF_EN is defined.
interface chunked_seq_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef CHUNKED_ADDER_OVF_EN
  logic             v;
`endif

  modport master (
    output in_valid, sub, cin, a, b, out_ready,
    input  in_ready, out_valid, s, cout
`ifdef CHUNKED_ADDER_OVF_EN
    , input v
`endif
  );

  modport slave (
    input  in_valid, sub, cin, a, b, out_ready,
    output in_ready, out_valid, s, cout
`ifdef CHUNKED_ADDER_OVF_EN
    , output v
`endif
  );
endinterface

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock.
// Define CHUNKED_ADDER_OVF_EN to add the signed-overflow output v.
module chunked_seq_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  chunked_seq_adder_if.slave bus
);
  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned OW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic             ready_d, valid_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q;
  logic             c;
  logic [IW-1:0]    idx;
  logic [OW-1:0]    ofs_c;
  logic [CHUNK-1:0] ca_c, cb_c, sum_c;
  logic [CHUNK:0]   full_c;
  logic             cy_c;
`ifdef CHUNKED_ADDER_OVF_EN
  logic             ovf_c;
`endif

  // Current chunk slice; subtraction inverts B and relies on the seeded carry.
  always_comb begin
    ofs_c  = OW'(32'(idx) * CHUNK);
    ca_c   = a_q[ofs_c +: CHUNK];
    cb_c   = b_q[ofs_c +: CHUNK] ^ {CHUNK{sub_q}};
    full_c = (CHUNK+1)'(ca_c) + (CHUNK+1)'(cb_c) + (CHUNK+1)'(c);
    sum_c  = full_c[CHUNK-1:0];
    cy_c   = full_c[CHUNK];
`ifdef CHUNKED_ADDER_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit.
    ovf_c  = (ca_c[CHUNK-1] ^ cb_c[CHUNK-1] ^ sum_c[CHUNK-1]) ^ cy_c;
`endif
  end

  // Next state plus next values of the registered handshake outputs.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (idx == LAST)   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      state         <= state_d;
      bus.in_ready  <= ready_d;
      bus.out_valid <= valid_d;
    end
  end

  // Operand capture and chunk-serial accumulation into the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      c        <= 1'b0;
      idx      <= '0;
      bus.s    <= '0;
      bus.cout <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      bus.v    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            sub_q <= bus.sub;
            c     <= bus.cin ^ bus.sub;
            idx   <= '0;
          end
        end
        RUN: begin
          bus.s[ofs_c +: CHUNK] <= sum_c;
          c                     <= cy_c;
          idx                   <= idx + IW'(1);
          if (idx == LAST) begin
            bus.cout <= cy_c;
`ifdef CHUNKED_ADDER_OVF_EN
            bus.v    <= ovf_c;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chunked_seq_adder.sv
// Scoreboard bench for chunked_seq_adder at 8/2, 16/16 and 16/1 configurations.
// Honours CHUNKED_ADDER_OVF_EN for the overflow checks.
module tb_chunked_seq_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ta, tb_b;
  logic        tsub, tcin, ordy;
  logic [2:0]  iv;

  chunked_seq_adder_if #(.WIDTH(8))  bus8 ();
  chunked_seq_adder_if #(.WIDTH(16)) bus16w ();
  chunked_seq_adder_if #(.WIDTH(16)) bus16n ();

  assign bus8.a = ta[7:0];    assign bus8.b = tb_b[7:0];
  assign bus8.sub = tsub;     assign bus8.cin = tcin;
  assign bus8.in_valid = iv[0]; assign bus8.out_ready = ordy;
  assign bus16w.a = ta;       assign bus16w.b = tb_b;
  assign bus16w.sub = tsub;   assign bus16w.cin = tcin;
  assign bus16w.in_valid = iv[1]; assign bus16w.out_ready = ordy;
  assign bus16n.a = ta;       assign bus16n.b = tb_b;
  assign bus16n.sub = tsub;   assign bus16n.cin = tcin;
  assign bus16n.in_valid = iv[2]; assign bus16n.out_ready = ordy;

  chunked_seq_adder #(.WIDTH(8),  .CHUNK(2))  dut8   (.clk(clk), .rst_n(rst_n), .bus(bus8));
  chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) dut16w (.clk(clk), .rst_n(rst_n), .bus(bus16w));
  chunked_seq_adder #(.WIDTH(16), .CHUNK(1))  dut16n (.clk(clk), .rst_n(rst_n), .bus(bus16n));

  logic [2:0]  ov, ir, co;
  logic [15:0] so [3];
  assign ov = {bus16n.out_valid, bus16w.out_valid, bus8.out_valid};
  assign ir = {bus16n.in_ready, bus16w.in_ready, bus8.in_ready};
  assign co = {bus16n.cout, bus16w.cout, bus8.cout};
  assign so[0] = {8'h00, bus8.s};
  assign so[1] = bus16w.s;
  assign so[2] = bus16n.s;
`ifdef CHUNKED_ADDER_OVF_EN
  logic [2:0] vv;
  assign vv = {bus16n.v, bus16w.v, bus8.v};
`endif

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        v;
  } exp_t;

  exp_t        sb [$];
  int          npass = 0;
  int          ntotal = 0;
  int unsigned wd [3] = '{8, 16, 16};
  int unsigned nc [3] = '{4, 1, 16};

  // Reference: plain two's-complement arithmetic on masked operands.
  function automatic exp_t model(input int unsigned w, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin);
    exp_t        e;
    logic [16:0] m, bx, full;
    m    = (17'd1 << w) - 17'd1;
    bx   = (sub ? {1'b0, ~b} : {1'b0, b}) & m;
    full = ({1'b0, a} & m) + bx + 17'(cin ^ sub);
    e.s    = 16'(full & m);
    e.cout = full[w];
    e.v    = (a[w-1] == bx[w-1]) && (full[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin);
    @(negedge clk);
    chk($sformatf("in_ready_before_accept[%0d]", k), 32'(ir[k]), 32'd1);
    ta = a; tb_b = b; tsub = sub; tcin = cin; iv[k] = 1'b1;
    @(posedge clk);
    sb.push_back(model(wd[k], a, b, sub, cin));
  endtask

  task automatic wait_result(input int k, input string tag);
    int   cyc;
    bit   seen;
    exp_t e;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      iv[k] = 1'b0;
      if (ov[k]) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    chk({tag, " latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(nc[k]));
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " s"}, 32'(so[k]), 32'(e.s));
      chk({tag, " cout"}, 32'(co[k]), 32'(e.cout));
`ifdef CHUNKED_ADDER_OVF_EN
      chk({tag, " v"}, 32'(vv[k]), 32'(e.v));
`endif
    end
  endtask

  task automatic finish_op(input int k, input string tag);
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " out_valid_after_hs"}, 32'(ov[k]), 32'd0);
    chk({tag, " in_ready_after_hs"}, 32'(ir[k]), 32'd1);
  endtask

  initial begin
    exp_t bp;
    int   extra;
    ta = '0; tb_b = '0; tsub = 1'b0; tcin = 1'b0; iv = '0; ordy = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset in_ready[%0d]", k), 32'(ir[k]), 32'd1);
      chk($sformatf("reset out_valid[%0d]", k), 32'(ov[k]), 32'd0);
      chk($sformatf("reset s[%0d]", k), 32'(so[k]), 32'd0);
      chk($sformatf("reset cout[%0d]", k), 32'(co[k]), 32'd0);
    end
    rst_n = 1'b1;

    // Directed 8-bit cases.
    issue(0, 16'h3C, 16'h45, 1'b0, 1'b1); wait_result(0, "add3c45"); finish_op(0, "add3c45");
    issue(0, 16'hFF, 16'h01, 1'b0, 1'b0); wait_result(0, "wrap");    finish_op(0, "wrap");
    issue(0, 16'h10, 16'h20, 1'b1, 1'b0); wait_result(0, "sub");     finish_op(0, "sub");
    issue(0, 16'h10, 16'h20, 1'b1, 1'b1); wait_result(0, "subbw");   finish_op(0, "subbw");
    issue(0, 16'h80, 16'h80, 1'b0, 1'b0); wait_result(0, "negovf");  finish_op(0, "negovf");

    // Backpressure: result must hold while inputs churn.
    bp = model(8, 16'h5A, 16'hC3, 1'b0, 1'b1);
    issue(0, 16'h5A, 16'hC3, 1'b0, 1'b1);
    wait_result(0, "bp");
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ta = 16'($urandom); tb_b = 16'($urandom); iv[0] = ~iv[0];
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp out_valid c%0d", i), 32'(ov[0]), 32'd1);
      chk($sformatf("bp in_ready c%0d", i), 32'(ir[0]), 32'd0);
      chk($sformatf("bp s c%0d", i), 32'(so[0]), 32'(bp.s));
      chk($sformatf("bp cout c%0d", i), 32'(co[0]), 32'(bp.cout));
    end
    iv[0] = 1'b0;
    finish_op(0, "bp");
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov[0]) extra++;
    end
    chk("bp single_result", 32'(extra), 32'd0);

    // Asynchronous reset while in RUN.
    issue(0, 16'hAA, 16'h55, 1'b0, 1'b0);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_run out_valid", 32'(ov[0]), 32'd0);
    chk("rst_run s", 32'(so[0]), 32'd0);
    chk("rst_run cout", 32'(co[0]), 32'd0);
    chk("rst_run in_ready", 32'(ir[0]), 32'd1);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov[0]) extra++;
    end
    chk("rst_run no_result", 32'(extra), 32'd0);
    chk("rst_run in_ready_after", 32'(ir[0]), 32'd1);

    // 16-bit extremes of chunk size.
    issue(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_result(1, "w16c16"); finish_op(1, "w16c16");
    issue(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_result(2, "w16c1");  finish_op(2, "w16c1");

    // Random operands on every configuration.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        issue(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        wait_result(k, $sformatf("rnd%0d_%0d", k, i));
        finish_op(k, $sformatf("rnd%0d_%0d", k, i));
      end
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
